// File: rtl/board_keeper.sv
// rtl/board_keeper.sv - tic-tac-toe board state keeper with move validation and win/draw detection
module board_keeper (
   input  logic       clk,
   input  logic       reset,
   input  logic       restart,
   input  logic       move_valid,
   input  logic [3:0] move_cell,
   output logic [8:0] x_status,
   output logic [8:0] o_status,
   output logic       turn,
   output logic       move_ack,
   output logic       move_err,
   output logic [1:0] game_state,
   output logic [3:0] move_count
);

   typedef enum logic [2:0] {X_TURN, O_TURN, CHECK, X_WON, O_WON, DRAW} state_t;

   state_t     state_q, state_d;
   logic [8:0] x_q, x_d, o_q, o_d;
   logic [3:0] count_q, count_d;
   logic       turn_q, turn_d, mover_q, mover_d;
   logic       ack_q, ack_d, err_q, err_d;
   logic [8:0] cell_bit;
   logic       cell_free;
   logic [8:0] mover_mask;

   function automatic logic has_line(input logic [8:0] m);
      has_line = (m[0] & m[1] & m[2]) | (m[3] & m[4] & m[5]) | (m[6] & m[7] & m[8]) |
                 (m[0] & m[3] & m[6]) | (m[1] & m[4] & m[7]) | (m[2] & m[5] & m[8]) |
                 (m[0] & m[4] & m[8]) | (m[2] & m[4] & m[6]);
   endfunction

   // Out-of-range cells shift the one past bit 8, leaving an all-zero mask.
   assign cell_bit   = 9'b1 << move_cell;
   assign cell_free  = (move_cell <= 4'd8) && ((cell_bit & (x_q | o_q)) == 9'b0);
   assign mover_mask = mover_q ? o_q : x_q;

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      o_d     = o_q;
      count_d = count_q;
      turn_d  = turn_q;
      mover_d = mover_q;
      ack_d   = 1'b0;
      err_d   = 1'b0;
      case (state_q)
         X_TURN, O_TURN: begin
            if (move_valid) begin
               if (cell_free) begin
                  ack_d   = 1'b1;
                  count_d = count_q + 4'd1;
                  mover_d = (state_q == O_TURN);
                  if (state_q == O_TURN) o_d = o_q | cell_bit;
                  else                   x_d = x_q | cell_bit;
                  state_d = CHECK;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         CHECK: begin
            err_d = move_valid;
            if (has_line(mover_mask)) begin
               state_d = mover_q ? O_WON : X_WON;
            end else if (count_q == 4'd9) begin
               state_d = DRAW;
            end else begin
               state_d = mover_q ? X_TURN : O_TURN;
               turn_d  = ~mover_q;
            end
         end
         default: err_d = move_valid;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset || restart) begin
         state_q <= X_TURN;
         x_q     <= 9'b0;
         o_q     <= 9'b0;
         count_q <= 4'd0;
         turn_q  <= 1'b0;
         mover_q <= 1'b0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         o_q     <= o_d;
         count_q <= count_d;
         turn_q  <= turn_d;
         mover_q <= mover_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      case (state_q)
         X_WON:   game_state = 2'b01;
         O_WON:   game_state = 2'b10;
         DRAW:    game_state = 2'b11;
         default: game_state = 2'b00;
      endcase
   end

   assign x_status   = x_q;
   assign o_status   = o_q;
   assign turn       = turn_q;
   assign move_ack   = ack_q;
   assign move_err   = err_q;
   assign move_count = count_q;

endmodule
